// File: rtl/seq_divider.sv
// Restoring divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient and remainder,
// one quotient bit per clock, go/done handshake shared with the shift-add multiplier.
//   state | meaning
//   IDLE  | waiting for go after reset
//   RUN   | shifting out quotient bits, cnt counts down to terminal 0
//   DONE  | result valid; accepts go like IDLE
module seq_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [15:0] din,
  input  logic [7:0]  dvin,
  output logic        done,
  output logic [7:0]  q,
  output logic [7:0]  r,
  output logic        ovf,
  output logic        divz
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  p_q, p_d;
  logic [7:0]  qs_q, qs_d;
  logic [7:0]  d_q, d_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic        ovf_q, ovf_d;
  logic        divz_q, divz_d;

  logic [8:0]  t;
  logic [8:0]  p_step;
  logic        qbit;
  logic [7:0]  qs_step;

  // partial remainder stays below D, so the shifted trial value fits in 9 bits
  always_comb begin
    t = {p_q[7:0], qs_q[7]};
    p_step = t;
    qbit = 1'b0;
    if (t >= {1'b0, d_q}) begin
      p_step = t - {1'b0, d_q};
      qbit = 1'b1;
    end
    qs_step = {qs_q[6:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    qs_d    = qs_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    divz_d  = divz_q;

    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          done_d = 1'b0;
          ovf_d  = 1'b0;
          divz_d = 1'b0;
          if (dvin == 8'd0) begin
            state_d = DONE;
            divz_d  = 1'b1;
            done_d  = 1'b1;
            q_d     = 8'd0;
            r_d     = 8'd0;
          end else if (din[15:8] >= dvin) begin
            state_d = DONE;
            ovf_d   = 1'b1;
            done_d  = 1'b1;
            q_d     = 8'd0;
            r_d     = 8'd0;
          end else begin
            state_d = RUN;
            p_d     = {1'b0, din[15:8]};
            qs_d    = din[7:0];
            d_d     = dvin;
            cnt_d   = 3'd7;
          end
        end
      end
      RUN: begin
        p_d  = p_step;
        qs_d = qs_step;
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
          q_d     = qs_step;
          r_d     = p_step[7:0];
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= 9'd0;
      qs_q    <= 8'd0;
      d_q     <= 8'd0;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
      q_q     <= 8'd0;
      r_q     <= 8'd0;
      ovf_q   <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      qs_q    <= qs_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      divz_q  <= divz_d;
    end
  end

  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign ovf  = ovf_q;
  assign divz = divz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus randomized bench for seq_divider; expected results come from
// plain integer division in the bench.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [15:0] din;
  logic [7:0]  dvin;
  logic        done;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        ovf;
  logic        divz;

  int checks = 0;
  int errors = 0;

  seq_divider dut (
    .clk(clk), .reset(reset), .go(go), .din(din), .dvin(dvin),
    .done(done), .q(q), .r(r), .ovf(ovf), .divz(divz)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic division with the error rules.
  task automatic model(input int a, input int b, output int eq, output int er,
                       output int eovf, output int edivz, output int elat);
    eq = 0; er = 0; eovf = 0; edivz = 0; elat = 1;
    if (b == 0) edivz = 1;
    else if (a / b > 255) eovf = 1;
    else begin
      eq = a / b;
      er = a % b;
      elat = 9;
    end
  endtask

  // Wait for done with a cycle budget; returns edges since the accepting edge.
  task automatic wait_done(input int start, output int n, input bit scramble);
    n = start;
    while (!done && n < 20) begin
      if (scramble) begin
        din  = 16'($urandom);
        dvin = 8'($urandom);
      end
      step();
      n++;
    end
  endtask

  task automatic run_div(input string tag, input int a, input int b, input bit inv);
    int eq, er, eovf, edivz, elat, n;
    model(a, b, eq, er, eovf, edivz, elat);
    din = 16'(a); dvin = 8'(b); go = 1'b1;
    step();
    go = 1'b0;
    din = 16'($urandom); dvin = 8'($urandom);
    wait_done(1, n, 1'b1);
    check({tag, "_latency"}, 16'(n), 16'(elat));
    check({tag, "_q"}, {8'd0, q}, 16'(eq));
    check({tag, "_r"}, {8'd0, r}, 16'(er));
    check({tag, "_ovf"}, {15'd0, ovf}, 16'(eovf));
    check({tag, "_divz"}, {15'd0, divz}, 16'(edivz));
    if (inv) begin
      check({tag, "_inv"}, 16'(int'(q) * b + int'(r)), 16'(a));
      check({tag, "_r_lt_d"}, {15'd0, (int'(r) < b)}, 16'd1);
    end
  endtask

  initial begin
    int n, a, b, hi;
    reset = 1'b1; go = 1'b0; din = 16'd0; dvin = 8'd0;
    step(); step();
    reset = 1'b0;
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_q", {8'd0, q}, 16'd0);
    check("rst_r", {8'd0, r}, 16'd0);
    check("rst_ovf", {15'd0, ovf}, 16'd0);
    check("rst_divz", {15'd0, divz}, 16'd0);

    run_div("basic", 1000, 7, 1'b1);
    repeat (4) step();
    check("hold_done", {15'd0, done}, 16'd1);
    check("hold_q", {8'd0, q}, 16'h8E);
    check("hold_r", {8'd0, r}, 16'h06);

    run_div("maxq1", 16'hFEFF, 8'hFF, 1'b1);
    run_div("maxq2", 16'h00FF, 8'h01, 1'b1);
    run_div("ovf1", 16'hFFFF, 8'hFF, 1'b0);
    run_div("ovf2", 16'h0500, 8'h05, 1'b0);
    run_div("divz1", 100, 0, 1'b0);
    run_div("divz2", 16'hFFFF, 0, 1'b0);

    // reset on the 4th RUN edge
    din = 16'd1000; dvin = 8'd7; go = 1'b1;
    step();
    go = 1'b0;
    repeat (3) step();
    check("mid_busy", {15'd0, done}, 16'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_done", {15'd0, done}, 16'd0);
    check("mid_rst_q", {8'd0, q}, 16'd0);
    check("mid_rst_r", {8'd0, r}, 16'd0);
    repeat (12) step();
    check("mid_idle_done", {15'd0, done}, 16'd0);
    run_div("after_rst", 1000, 7, 1'b1);

    // back-to-back with go held high
    din = 16'd1000; dvin = 8'd7; go = 1'b1;
    step();
    wait_done(1, n, 1'b1);
    check("b2b1_latency", 16'(n), 16'd9);
    check("b2b1_q", {8'd0, q}, 16'h8E);
    check("b2b1_r", {8'd0, r}, 16'h06);
    din = 16'd255; dvin = 8'd16;
    step();
    check("b2b_pulse", {15'd0, done}, 16'd0);
    wait_done(1, n, 1'b1);
    check("b2b2_latency", 16'(n), 16'd9);
    check("b2b2_q", {8'd0, q}, 16'h0F);
    check("b2b2_r", {8'd0, r}, 16'h0F);
    go = 1'b0;
    step();

    for (int i = 0; i < 1000; i++) begin
      b = $urandom_range(1, 255);
      hi = $urandom_range(0, b - 1);
      a = hi * 256 + $urandom_range(0, 255);
      run_div("rand", a, b, 1'b1);
    end
    for (int i = 0; i < 50; i++) begin
      b = (i % 5 == 0) ? 0 : $urandom_range(1, 255);
      a = $urandom_range(0, 65535);
      run_div("rand_any", a, b, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
